// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader:
// FSM state encodings and stream word geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_DATA = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Accepts stream bytes and packs them MSB-first into 32-bit words, strobing
// in the cycle the final byte of a word is accepted.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        word_strobe_o,
  output logic [31:0] word_o
);

  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic                  accept;

  // A clear on the same cycle as a valid byte drops that byte.
  assign accept        = in_valid_i && enable_i && !clear_i;
  assign word_strobe_o = accept && (byte_cnt_q == BYTE_CNT_W'(WORD_BYTES - 1));
  assign word_o        = {shift_q, in_data_i};

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    if (clear_i) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (accept) begin
      byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
      shift_d    = {shift_q[15:0], in_data_i};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length-prefixed byte stream, writes the words to
// instruction memory and holds the CPU in reset until the program is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    word_idx_q, word_idx_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                word_strobe;
  logic [31:0]         word;

  imem_loader_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (reload),
    .enable_i      (in_ready),
    .in_valid_i    (in_valid),
    .in_data_i     (in_data),
    .word_strobe_o (word_strobe),
    .word_o        (word)
  );

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (reload) begin
      state_d    = ST_HDR;
      word_idx_d = '0;
    end else if (word_strobe) begin
      unique case (state_q)
        ST_HDR: begin
          count_d = CNT_W'(word);
          if (word == 32'd0)                   state_d = ST_RUN;
          else if (word > 32'(MAX_WORDS))      state_d = ST_ERR;
          else                                 state_d = ST_DATA;
        end
        ST_DATA: begin
          mem_we_d    = 1'b1;
          mem_wdata_d = word;
          mem_addr_d  = ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx_q);
          word_idx_d  = word_idx_q + CNT_W'(1);
          if (word_idx_q == count_q - CNT_W'(1)) state_d = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_HDR;
      count_q     <= '0;
      word_idx_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The last write lands as the FSM enters RUN; the CPU is released one
  // cycle later, once that write has reached memory.
  assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign done      = (state_q == ST_RUN) && !mem_we_q;
  assign cpu_hold  = !done;
  assign error     = (state_q == ST_ERR);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal load, empty and
// oversize headers, reload, stream gaps and mid-stream reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        reload;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [9:0]  wr_addr [0:15];
  logic [31:0] wr_data [0:15];
  int          wr_n = 0;
  int          base;

  imem_loader #(.ADDR_W(10), .BASE_ADDR(0), .MAX_WORDS(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (wr_n < 16) begin
        wr_addr[wr_n] = mem_addr;
        wr_data[wr_n] = mem_wdata;
      end
      wr_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(w[31 - 8*i -: 8]);
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  in_ready,  1);
    check({tag, " mem_we"},    mem_we,    0);
    check({tag, " mem_addr"},  mem_addr,  0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " cpu_hold"},  cpu_hold,  1);
    check({tag, " done"},      done,      0);
    check({tag, " error"},     error,     0);
  endtask

  // Loads the two-word program and checks the write/release timing.
  task automatic load_prog1(input string tag, input int max_gap);
    base = wr_n;
    send_word(32'h0000_0002, max_gap);
    send_word(32'h2008_0005, max_gap);
    send_word(32'h2009_000A, max_gap);
    check({tag, " last mem_we"},    mem_we,    1);
    check({tag, " last addr"},      mem_addr,  1);
    check({tag, " last wdata"},     mem_wdata, 32'h2009_000A);
    check({tag, " hold during we"}, cpu_hold,  1);
    @(negedge clk);
    check({tag, " we drops"},       mem_we,    0);
    check({tag, " cpu_hold"},       cpu_hold,  0);
    check({tag, " done"},           done,      1);
    check({tag, " in_ready"},       in_ready,  0);
    check({tag, " addr holds"},     mem_addr,  1);
    check({tag, " write count"},    wr_n - base, 2);
    check({tag, " w0 addr"},        wr_addr[base],     0);
    check({tag, " w0 data"},        wr_data[base],     32'h2008_0005);
    check({tag, " w1 addr"},        wr_addr[base + 1], 1);
    check({tag, " w1 data"},        wr_data[base + 1], 32'h2009_000A);
  endtask

  initial begin
    reset    = 1'b0;
    reload   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    load_prog1("t1", 0);

    // Reload from RUN, then a one-word program of zero.
    pulse_reload();
    check("t6 hold after reload", cpu_hold, 1);
    check("t6 done after reload", done,     0);
    check("t6 in_ready",          in_ready, 1);
    base = wr_n;
    send_word(32'h0000_0001, 0);
    send_word(32'h0000_0000, 0);
    check("t6 mem_we", mem_we,    1);
    check("t6 addr",   mem_addr,  0);
    check("t6 wdata",  mem_wdata, 0);
    @(negedge clk);
    check("t6 done",   done,     1);
    check("t6 hold",   cpu_hold, 0);
    check("t6 writes", wr_n - base, 1);

    // Empty program: straight to RUN, nothing written.
    pulse_reload();
    base = wr_n;
    send_word(32'h0000_0000, 0);
    check("t2 done",     done,     1);
    check("t2 cpu_hold", cpu_hold, 0);
    check("t2 in_ready", in_ready, 0);
    check("t2 mem_we",   mem_we,   0);
    repeat (3) @(negedge clk);
    check("t2 writes",   wr_n - base, 0);

    // Oversize header.
    pulse_reload();
    base = wr_n;
    send_word(32'h0000_0401, 0);
    check("t3 error",    error,    1);
    check("t3 cpu_hold", cpu_hold, 1);
    check("t3 in_ready", in_ready, 0);
    check("t3 done",     done,     0);
    send_word(32'hDEAD_BEEF, 0);
    @(negedge clk);
    check("t3 writes",   wr_n - base, 0);
    pulse_reload();
    check("t3 error clr", error,    0);
    check("t3 ready",     in_ready, 1);

    // Exactly MAX_WORDS is accepted.
    send_word(32'h0000_0400, 0);
    check("max error",   error,    0);
    check("max ready",   in_ready, 1);
    check("max hold",    cpu_hold, 1);

    // Partial word discarded; byte coinciding with reload dropped.
    pulse_reload();
    send_byte(8'hAA);
    send_byte(8'hBB);
    reload   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(negedge clk);
    reload   = 1'b0;
    in_valid = 1'b0;
    base = wr_n;
    send_word(32'h0000_0001, 0);
    check("rw error",  error, 0);
    send_word(32'h1234_5678, 0);
    check("rw addr",   mem_addr,  0);
    check("rw wdata",  mem_wdata, 32'h1234_5678);
    @(negedge clk);
    check("rw done",   done, 1);
    check("rw writes", wr_n - base, 1);

    // Same program with idle gaps between bytes.
    pulse_reload();
    load_prog1("t4", 5);

    // Reset mid-word, then reload the program from the start.
    pulse_reload();
    send_word(32'h0000_0002, 0);
    send_byte(8'h20);
    send_byte(8'h08);
    reset = 1'b0;
    #1;
    check_reset_outputs("t5 async");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load_prog1("t5", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
